// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-compatible PIC blocks: acknowledge
// sequencer states, vector field widths and one-hot level decode.
package pic_pkg;

   localparam int T_W   = 5;
   localparam int LVL_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      ACK1,
      GAP,
      ACK2
   } inta_state_e;

   function automatic logic [7:0] onehot8(input logic [LVL_W-1:0] idx);
      onehot8 = 8'h01 << idx;
   endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Registers the (already synchronous) INTA_N line and produces one-cycle
// fall/rise pulses relative to the previous sample.
module inta_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic inta_n_i,
   output logic fall_o,
   output logic rise_o
);

   logic inta_q;

   // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) inta_q <= 1'b1;
      else          inta_q <= inta_n_i;
   end

   assign fall_o = inta_q & ~inta_n_i;
   assign rise_o = ~inta_q & inta_n_i;

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer: raises INT, runs the two-pulse
// INTA handshake, handles cascade addressing and issues ISR set/clear pulses.
module inta_sequencer
   import pic_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             INTA_N,
   input  logic             SP,
   input  logic             SNGL,
   input  logic             AEOI,
   input  logic [7:0]       ICW3,
   input  logic [T_W-1:0]   T,
   input  logic             INT_REQ,
   input  logic [LVL_W-1:0] IR_LEVEL,
   input  logic [2:0]       CAS_IN,
   output logic             INT,
   output logic [2:0]       CAS_OUT,
   output logic             CAS_OE,
   output logic [7:0]       DATA_OUT,
   output logic             DATA_OE,
   output logic [7:0]       ISR_SET,
   output logic [7:0]       ISR_CLR,
   output logic             FREEZE
);

   logic fall, rise;

   inta_edge_detect u_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .inta_n_i (INTA_N),
      .fall_o   (fall),
      .rise_o   (rise)
   );

   inta_state_e      state_q, state_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             valid_q, valid_d;
   logic             cascaded_q, cascaded_d;
   logic             selected_q, selected_d;
   logic             int_q, int_d;
   logic [2:0]       cas_out_q, cas_out_d;
   logic             cas_oe_q, cas_oe_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             data_oe_q, data_oe_d;
   logic [7:0]       isr_set_q, isr_set_d;
   logic [7:0]       isr_clr_q, isr_clr_d;
   logic             freeze_q, freeze_d;

   logic is_slave;
   logic drive_vec;

   // A slave in single mode behaves like a stand-alone device.
   assign is_slave  = ~SP & ~SNGL;
   assign drive_vec = SNGL | (SP & ~cascaded_q) | (is_slave & selected_q);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      lvl_d      = lvl_q;
      valid_d    = valid_q;
      cascaded_d = cascaded_q;
      selected_d = selected_q;
      int_d      = int_q;
      cas_out_d  = cas_out_q;
      cas_oe_d   = cas_oe_q;
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      isr_set_d  = '0;
      isr_clr_d  = '0;
      freeze_d   = freeze_q;

      case (state_q)
         IDLE: begin
            if (INT_REQ) begin
               state_d = PEND;
               int_d   = 1'b1;
            end
         end
         PEND: begin
            if (fall) begin
               state_d    = ACK1;
               int_d      = 1'b0;
               freeze_d   = 1'b1;
               valid_d    = INT_REQ;
               lvl_d      = INT_REQ ? IR_LEVEL : 3'b111;
               cascaded_d = SP & ~SNGL & ICW3[lvl_d];
               cas_oe_d   = cascaded_d;
               cas_out_d  = cascaded_d ? lvl_d : 3'b000;
               selected_d = (CAS_IN == ICW3[2:0]);
               if (INT_REQ && !is_slave) isr_set_d = onehot8(IR_LEVEL);
            end
         end
         ACK1: begin
            if (rise) state_d = GAP;
         end
         GAP: begin
            if (fall) begin
               state_d = ACK2;
               if (drive_vec) begin
                  data_oe_d  = 1'b1;
                  data_out_d = {T, lvl_q};
               end
               // A slave only learns it owns the request once CAS has been decoded.
               if (is_slave && selected_q && valid_q) isr_set_d = onehot8(lvl_q);
            end
         end
         ACK2: begin
            if (rise) begin
               state_d    = IDLE;
               cas_oe_d   = 1'b0;
               cas_out_d  = 3'b000;
               data_oe_d  = 1'b0;
               data_out_d = 8'h00;
               freeze_d   = 1'b0;
               cascaded_d = 1'b0;
               selected_d = 1'b0;
               if (AEOI && valid_q && (!is_slave || selected_q)) isr_clr_d = onehot8(lvl_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         lvl_q      <= '0;
         valid_q    <= 1'b0;
         cascaded_q <= 1'b0;
         selected_q <= 1'b0;
         int_q      <= 1'b0;
         cas_out_q  <= '0;
         cas_oe_q   <= 1'b0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         isr_set_q  <= '0;
         isr_clr_q  <= '0;
         freeze_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lvl_q      <= lvl_d;
         valid_q    <= valid_d;
         cascaded_q <= cascaded_d;
         selected_q <= selected_d;
         int_q      <= int_d;
         cas_out_q  <= cas_out_d;
         cas_oe_q   <= cas_oe_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         isr_set_q  <= isr_set_d;
         isr_clr_q  <= isr_clr_d;
         freeze_q   <= freeze_d;
      end
   end

   assign INT      = int_q;
   assign CAS_OUT  = cas_out_q;
   assign CAS_OE   = cas_oe_q;
   assign DATA_OUT = data_out_q;
   assign DATA_OE  = data_oe_q;
   assign ISR_SET  = isr_set_q;
   assign ISR_CLR  = isr_clr_q;
   assign FREEZE   = freeze_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: single, master, slave, spurious, AEOI
// and mid-sequence reset scenarios with hand-computed expectations.
module tb_inta_sequencer;

   logic       clk;
   logic       reset_n;
   logic       INTA_N;
   logic       SP;
   logic       SNGL;
   logic       AEOI;
   logic [7:0] ICW3;
   logic [4:0] T;
   logic       INT_REQ;
   logic [2:0] IR_LEVEL;
   logic [2:0] CAS_IN;
   logic       INT;
   logic [2:0] CAS_OUT;
   logic       CAS_OE;
   logic [7:0] DATA_OUT;
   logic       DATA_OE;
   logic [7:0] ISR_SET;
   logic [7:0] ISR_CLR;
   logic       FREEZE;

   int n_tests = 0;
   int n_fail  = 0;

   inta_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .INTA_N   (INTA_N),
      .SP       (SP),
      .SNGL     (SNGL),
      .AEOI     (AEOI),
      .ICW3     (ICW3),
      .T        (T),
      .INT_REQ  (INT_REQ),
      .IR_LEVEL (IR_LEVEL),
      .CAS_IN   (CAS_IN),
      .INT      (INT),
      .CAS_OUT  (CAS_OUT),
      .CAS_OE   (CAS_OE),
      .DATA_OUT (DATA_OUT),
      .DATA_OE  (DATA_OE),
      .ISR_SET  (ISR_SET),
      .ISR_CLR  (ISR_CLR),
      .FREEZE   (FREEZE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are observed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [30:0] all_outs();
      return {INT, CAS_OE, DATA_OE, FREEZE, CAS_OUT, DATA_OUT, ISR_SET, ISR_CLR};
   endfunction

   task automatic run_ack(input string nm, input logic spurious, input logic [2:0] lvl,
                          input logic [7:0] e_set1, input logic e_cas_oe, input logic [2:0] e_cas_out,
                          input logic e_doe, input logic [7:0] e_dout,
                          input logic [7:0] e_set2, input logic [7:0] e_clr);
      INT_REQ  = 1'b1;
      IR_LEVEL = lvl;
      tick();
      check({nm, ":int_rise"}, INT, 1);
      if (spurious) begin
         INT_REQ = 1'b0;
         tick();
         check({nm, ":int_hold"}, INT, 1);
      end
      INTA_N = 1'b0;
      tick();
      check({nm, ":int_fall"}, INT, 0);
      check({nm, ":isr_set_ack1"}, ISR_SET, e_set1);
      check({nm, ":freeze_ack1"}, FREEZE, 1);
      check({nm, ":cas_oe_ack1"}, CAS_OE, e_cas_oe);
      check({nm, ":cas_out_ack1"}, CAS_OUT, e_cas_out);
      check({nm, ":data_oe_ack1"}, DATA_OE, 0);
      INT_REQ = 1'b0;
      tick();
      check({nm, ":isr_set_pulse"}, ISR_SET, 0);
      INTA_N = 1'b1;
      tick();
      check({nm, ":data_oe_gap"}, DATA_OE, 0);
      check({nm, ":cas_oe_gap"}, CAS_OE, e_cas_oe);
      INTA_N = 1'b0;
      tick();
      check({nm, ":data_oe_ack2"}, DATA_OE, e_doe);
      check({nm, ":data_out_ack2"}, DATA_OUT, e_dout);
      check({nm, ":isr_set_ack2"}, ISR_SET, e_set2);
      tick();
      check({nm, ":data_oe_hold"}, DATA_OE, e_doe);
      check({nm, ":cas_oe_hold"}, CAS_OE, e_cas_oe);
      check({nm, ":freeze_hold"}, FREEZE, 1);
      INTA_N = 1'b1;
      tick();
      check({nm, ":data_oe_end"}, DATA_OE, 0);
      check({nm, ":cas_oe_end"}, CAS_OE, 0);
      check({nm, ":freeze_end"}, FREEZE, 0);
      check({nm, ":isr_clr"}, ISR_CLR, e_clr);
      tick();
      check({nm, ":isr_clr_pulse"}, ISR_CLR, 0);
      check({nm, ":idle_int"}, INT, 0);
   endtask

   initial begin
      reset_n  = 1'b0;
      INTA_N   = 1'b1;
      SP       = 1'b1;
      SNGL     = 1'b1;
      AEOI     = 1'b0;
      ICW3     = 8'h00;
      T        = 5'b01000;
      INT_REQ  = 1'b0;
      IR_LEVEL = 3'd0;
      CAS_IN   = 3'd0;
      tick();
      tick();
      check("reset_outs", all_outs(), 0);
      reset_n = 1'b1;
      tick();
      check("idle_outs", all_outs(), 0);

      // Single device: vector {01000,011} = 0x43.
      run_ack("single", 1'b0, 3'd3, 8'h08, 1'b0, 3'd0, 1'b1, 8'h43, 8'h00, 8'h00);

      // Master, slave hangs on IR3: CAS carries the level, vector comes from the slave.
      SNGL = 1'b0;
      SP   = 1'b1;
      ICW3 = 8'h09;
      run_ack("master_cas", 1'b0, 3'd3, 8'h08, 1'b1, 3'd3, 1'b0, 8'h00, 8'h00, 8'h00);
      // Same master, IR2 has no slave: master supplies {01000,010} = 0x42.
      run_ack("master_flat", 1'b0, 3'd2, 8'h04, 1'b0, 3'd0, 1'b1, 8'h42, 8'h00, 8'h00);

      // Slave with ID 3, addressed: vector {10000,101} = 0x85, ISR set at ACK2.
      SP     = 1'b0;
      ICW3   = 8'h03;
      T      = 5'b10000;
      CAS_IN = 3'b011;
      AEOI   = 1'b1;
      run_ack("slave_sel", 1'b0, 3'd5, 8'h00, 1'b0, 3'd0, 1'b1, 8'h85, 8'h20, 8'h20);
      AEOI   = 1'b0;
      CAS_IN = 3'b000;
      run_ack("slave_unsel", 1'b0, 3'd5, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);

      // Spurious in single mode: level forced to 7, no ISR activity even with AEOI.
      SP   = 1'b1;
      SNGL = 1'b1;
      T    = 5'b01000;
      AEOI = 1'b1;
      run_ack("spurious", 1'b1, 3'd2, 8'h00, 1'b0, 3'd0, 1'b1, 8'h47, 8'h00, 8'h00);

      // AEOI at level 6: set 0x40 in ACK1, clear 0x40 after the second rise.
      run_ack("aeoi", 1'b0, 3'd6, 8'h40, 1'b0, 3'd0, 1'b1, 8'h46, 8'h00, 8'h40);

      // Reset while in GAP.
      INT_REQ  = 1'b1;
      IR_LEVEL = 3'd4;
      tick();
      INTA_N = 1'b0;
      tick();
      INT_REQ = 1'b0;
      tick();
      INTA_N = 1'b1;
      tick();
      check("gap_freeze", FREEZE, 1);
      reset_n = 1'b0;
      tick();
      check("mid_reset_outs", all_outs(), 0);
      reset_n = 1'b1;
      tick();
      check("post_reset_outs", all_outs(), 0);
      INTA_N = 1'b0;
      tick();
      check("stray_pulse_low", all_outs(), 0);
      tick();
      INTA_N = 1'b1;
      tick();
      check("stray_pulse_end", all_outs(), 0);
      tick();
      check("stray_pulse_after", all_outs(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
